// File: rtl/pos_oscillator.sv
// Single-axis position engine for moving game blocks.
// Bounce / wrap / stop sweeps with load, freeze-capture and bound pulse.
module pos_oscillator #(
    parameter int WIDTH   = 8,
    parameter int MIN_POS = 0,
    parameter int MAX_POS = 144,
    parameter int STEP_W  = 3
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              tick,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_pos,
    input  logic              load_dir,
    input  logic              freeze,
    output logic [WIDTH-1:0]  pos,
    output logic              dir,
    output logic              at_bound,
    output logic              done,
    output logic [WIDTH-1:0]  frozen_pos,
    output logic              frozen_vld
);

    localparam logic [WIDTH-1:0] MINP = WIDTH'(MIN_POS);
    localparam logic [WIDTH-1:0] MAXP = WIDTH'(MAX_POS);
    localparam logic [WIDTH:0] MINW = (WIDTH+1)'(MIN_POS);
    localparam logic [WIDTH:0] MAXW = (WIDTH+1)'(MAX_POS);
    localparam logic signed [WIDTH+1:0] MIN_S = (WIDTH+2)'(MIN_POS);
    localparam logic signed [WIDTH+1:0] MAX_S = (WIDTH+2)'(MAX_POS);

    logic [WIDTH:0]   pos_w;
    logic [WIDTH:0]   step_w;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   dn_dif;
    logic [WIDTH:0]   lo_lim;
    logic             hit;
    logic [WIDTH-1:0] mv_pos;
    logic             mv_dir;
    logic             mv_stop;

    logic signed [WIDTH+1:0] ld_s;
    logic [WIDTH-1:0]        ld_clamp;

    // Next position/direction for a motion tick, in WIDTH+1 bits.
    always_comb begin
        pos_w   = {1'b0, pos};
        step_w  = {{(WIDTH+1-STEP_W){1'b0}}, step};
        up_sum  = pos_w + step_w;
        dn_dif  = pos_w - step_w;
        lo_lim  = MINW + step_w;
        hit     = 1'b0;
        mv_pos  = pos;
        mv_dir  = dir;
        mv_stop = 1'b0;
        if (step != '0) begin
            if (dir) begin
                hit = (up_sum >= MAXW);
            end else begin
                hit = (pos_w <= lo_lim);
            end
        end
        if (!hit) begin
            mv_pos = dir ? up_sum[WIDTH-1:0] : dn_dif[WIDTH-1:0];
            if (step == '0) begin
                mv_pos = pos;
            end
        end else begin
            case (mode)
                2'b01: begin
                    mv_pos = dir ? MINP : MAXP;
                end
                2'b10: begin
                    mv_pos  = dir ? MAXP : MINP;
                    mv_stop = 1'b1;
                end
                default: begin
                    mv_pos = dir ? MAXP : MINP;
                    mv_dir = ~dir;
                end
            endcase
        end
    end

    // Clamp the load value into the legal position range.
    always_comb begin
        ld_s     = $signed({2'b00, load_pos});
        ld_clamp = load_pos;
        if (ld_s > MAX_S) begin
            ld_clamp = MAXP;
        end else if (ld_s < MIN_S) begin
            ld_clamp = MINP;
        end
    end

    // All state: reset, then load, then freeze, then a motion tick.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pos        <= MINP;
            dir        <= 1'b1;
            at_bound   <= 1'b0;
            done       <= 1'b0;
            frozen_pos <= '0;
            frozen_vld <= 1'b0;
        end else begin
            at_bound <= 1'b0;
            if (load) begin
                pos        <= ld_clamp;
                dir        <= load_dir;
                done       <= 1'b0;
                frozen_vld <= 1'b0;
            end else if (freeze) begin
                frozen_pos <= pos;
                frozen_vld <= 1'b1;
                done       <= 1'b1;
            end else if (tick && enable && !done) begin
                pos      <= mv_pos;
                dir      <= mv_dir;
                at_bound <= hit;
                if (mv_stop) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
